// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: pipeline-register fields observed by the hazard unit and
// the PC/buffer enables and flushes it drives back into the datapath.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ex_MemRead;
    logic [4:0]       ex_rt;
    logic             mem_Branch;
    logic             mem_Z_flag;
    logic             mem_MemRead;
    logic             mem_MemWRITE;

    logic             pc_we;
    logic             pc_sel_branch;
    logic             b1_we;
    logic             b2_we;
    logic             b3_we;
    logic             b4_we;
    logic             b1_flush;
    logic             b2_flush;
    logic             b3_flush;
    logic             state;
    logic [CNT_W-1:0] stall_count;

    // Datapath side: presents pipeline fields, consumes controls.
    modport master (
        output id_rs, id_rt, ex_MemRead, ex_rt,
               mem_Branch, mem_Z_flag, mem_MemRead, mem_MemWRITE,
        input  pc_we, pc_sel_branch, b1_we, b2_we, b3_we, b4_we,
               b1_flush, b2_flush, b3_flush, state, stall_count
    );

    // Hazard-unit side.
    modport slave (
        input  id_rs, id_rt, ex_MemRead, ex_rt,
               mem_Branch, mem_Z_flag, mem_MemRead, mem_MemWRITE,
        output pc_we, pc_sel_branch, b1_we, b2_we, b3_we, b4_we,
               b1_flush, b2_flush, b3_flush, state, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use stalls, taken-branch
// flushes resolved in MEM, and a freeze while a multi-cycle memory access completes.
module pipeline_hazard_ctrl #(
    parameter int MEM_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave ctrl
);
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int WC_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [WC_W-1:0] WAIT_INIT = WC_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
    localparam bit FREEZE_EN = (MEM_LAT > 1);

    state_t           state_r, state_n;
    logic [WC_W-1:0]  wait_cnt, wait_n;
    logic [CNT_W-1:0] stall_q;
    logic             memop, taken, load_use, freeze;

    assign memop    = ctrl.mem_MemRead | ctrl.mem_MemWRITE;
    assign taken    = ctrl.mem_Branch & ctrl.mem_Z_flag;
    assign load_use = ctrl.ex_MemRead && (ctrl.ex_rt != 5'd0) &&
                      ((ctrl.ex_rt == ctrl.id_rs) || (ctrl.ex_rt == ctrl.id_rt));

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        freeze  = 1'b0;
        state_n = state_r;
        wait_n  = wait_cnt;

        unique case (state_r)
            RUN: begin
                if (memop && FREEZE_EN) begin
                    freeze  = 1'b1;
                    state_n = MEM_WAIT;
                    wait_n  = WAIT_INIT;
                end
            end
            MEM_WAIT: begin
                // The release cycle must not re-freeze on the op that is just leaving MEM.
                if (wait_cnt != '0) begin
                    freeze = 1'b1;
                    wait_n = wait_cnt - WC_W'(1);
                end else begin
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase

        ctrl.pc_we         = 1'b1;
        ctrl.pc_sel_branch = 1'b0;
        ctrl.b1_we         = 1'b1;
        ctrl.b2_we         = 1'b1;
        ctrl.b3_we         = 1'b1;
        ctrl.b4_we         = 1'b1;
        ctrl.b1_flush      = 1'b0;
        ctrl.b2_flush      = 1'b0;
        ctrl.b3_flush      = 1'b0;

        if (rst) begin
            ctrl.pc_we    = 1'b0;
            ctrl.b1_we    = 1'b0;
            ctrl.b2_we    = 1'b0;
            ctrl.b3_we    = 1'b0;
            ctrl.b4_we    = 1'b0;
            ctrl.b1_flush = 1'b1;
            ctrl.b2_flush = 1'b1;
            ctrl.b3_flush = 1'b1;
        end else if (freeze) begin
            ctrl.pc_we = 1'b0;
            ctrl.b1_we = 1'b0;
            ctrl.b2_we = 1'b0;
            ctrl.b3_we = 1'b0;
            ctrl.b4_we = 1'b0;
        end else if (taken) begin
            ctrl.pc_sel_branch = 1'b1;
            ctrl.b1_flush      = 1'b1;
            ctrl.b2_flush      = 1'b1;
            ctrl.b3_flush      = 1'b1;
        end else if (load_use) begin
            // One bubble: hold PC and IF/ID, inject a NOP into ID/EX.
            ctrl.pc_we    = 1'b0;
            ctrl.b1_we    = 1'b0;
            ctrl.b2_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_r  <= RUN;
            wait_cnt <= '0;
            stall_q  <= '0;
        end else begin
            state_r  <= state_n;
            wait_cnt <= wait_n;
            if (!ctrl.pc_we && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign ctrl.state       = logic'(state_r);
    assign ctrl.stall_count = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: four controller instances with different MEM_LAT/CNT_W share one
// stimulus stream; each scenario task checks the relevant instance against hand values.
module tb_pipeline_hazard_ctrl;
    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_MemRead, mem_Branch, mem_Z_flag, mem_MemRead, mem_MemWRITE;
    int         passed;
    int         total;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) if_a ();  // MEM_LAT=3
    pipeline_hazard_ctrl_if #(.CNT_W(16)) if_b ();  // MEM_LAT=1
    pipeline_hazard_ctrl_if #(.CNT_W(16)) if_c ();  // MEM_LAT=4
    pipeline_hazard_ctrl_if #(.CNT_W(4))  if_d ();  // MEM_LAT=3, narrow counter

    assign if_a.id_rs = id_rs; assign if_a.id_rt = id_rt; assign if_a.ex_rt = ex_rt;
    assign if_a.ex_MemRead = ex_MemRead; assign if_a.mem_Branch = mem_Branch;
    assign if_a.mem_Z_flag = mem_Z_flag; assign if_a.mem_MemRead = mem_MemRead;
    assign if_a.mem_MemWRITE = mem_MemWRITE;
    assign if_b.id_rs = id_rs; assign if_b.id_rt = id_rt; assign if_b.ex_rt = ex_rt;
    assign if_b.ex_MemRead = ex_MemRead; assign if_b.mem_Branch = mem_Branch;
    assign if_b.mem_Z_flag = mem_Z_flag; assign if_b.mem_MemRead = mem_MemRead;
    assign if_b.mem_MemWRITE = mem_MemWRITE;
    assign if_c.id_rs = id_rs; assign if_c.id_rt = id_rt; assign if_c.ex_rt = ex_rt;
    assign if_c.ex_MemRead = ex_MemRead; assign if_c.mem_Branch = mem_Branch;
    assign if_c.mem_Z_flag = mem_Z_flag; assign if_c.mem_MemRead = mem_MemRead;
    assign if_c.mem_MemWRITE = mem_MemWRITE;
    assign if_d.id_rs = id_rs; assign if_d.id_rt = id_rt; assign if_d.ex_rt = ex_rt;
    assign if_d.ex_MemRead = ex_MemRead; assign if_d.mem_Branch = mem_Branch;
    assign if_d.mem_Z_flag = mem_Z_flag; assign if_d.mem_MemRead = mem_MemRead;
    assign if_d.mem_MemWRITE = mem_MemWRITE;

    pipeline_hazard_ctrl #(.MEM_LAT(3), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .ctrl(if_a));
    pipeline_hazard_ctrl #(.MEM_LAT(1), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .ctrl(if_b));
    pipeline_hazard_ctrl #(.MEM_LAT(4), .CNT_W(16)) dut_c (.clk(clk), .rst(rst), .ctrl(if_c));
    pipeline_hazard_ctrl #(.MEM_LAT(3), .CNT_W(4))  dut_d (.clk(clk), .rst(rst), .ctrl(if_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; ex_MemRead = 1'b0;
        mem_Branch = 1'b0; mem_Z_flag = 1'b0; mem_MemRead = 1'b0; mem_MemWRITE = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd0;
        mem_Branch = 1'b1; mem_Z_flag = 1'b1; mem_MemRead = 1'b1; mem_MemWRITE = 1'b0;
        tick();
        total++; if (if_a.pc_we !== 1'b0) $display("FAIL rst_pc_we got=%b exp=0", if_a.pc_we); else passed++;
        total++; if (if_a.b1_we !== 1'b0) $display("FAIL rst_b1_we got=%b exp=0", if_a.b1_we); else passed++;
        total++; if (if_a.b4_we !== 1'b0) $display("FAIL rst_b4_we got=%b exp=0", if_a.b4_we); else passed++;
        total++; if ({if_a.b1_flush, if_a.b2_flush, if_a.b3_flush} !== 3'b111)
            $display("FAIL rst_flush got=%b exp=111", {if_a.b1_flush, if_a.b2_flush, if_a.b3_flush}); else passed++;
        total++; if (if_a.pc_sel_branch !== 1'b0) $display("FAIL rst_pc_sel got=%b exp=0", if_a.pc_sel_branch); else passed++;
        tick();
        rst = 1'b0;
        idle();
        #1;
        total++; if (if_a.state !== 1'b0) $display("FAIL rst_state got=%b exp=0", if_a.state); else passed++;
        total++; if (if_a.stall_count !== 16'd0) $display("FAIL rst_count got=%0d exp=0", if_a.stall_count); else passed++;
        total++; if (if_d.stall_count !== 4'd0) $display("FAIL rst_count_d got=%0d exp=0", if_d.stall_count); else passed++;
        total++; if (if_a.pc_we !== 1'b1) $display("FAIL idle_pc_we got=%b exp=1", if_a.pc_we); else passed++;
        total++; if ({if_a.b1_we, if_a.b2_we, if_a.b3_we, if_a.b4_we} !== 4'b1111)
            $display("FAIL idle_we got=%b exp=1111", {if_a.b1_we, if_a.b2_we, if_a.b3_we, if_a.b4_we}); else passed++;
        total++; if ({if_a.b1_flush, if_a.b2_flush, if_a.b3_flush} !== 3'b000)
            $display("FAIL idle_flush got=%b exp=000", {if_a.b1_flush, if_a.b2_flush, if_a.b3_flush}); else passed++;
    endtask

    task automatic test_load_use();
        apply_reset();
        ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd0;
        #1;
        total++; if (if_a.pc_we !== 1'b0) $display("FAIL lu_pc_we got=%b exp=0", if_a.pc_we); else passed++;
        total++; if (if_a.b1_we !== 1'b0) $display("FAIL lu_b1_we got=%b exp=0", if_a.b1_we); else passed++;
        total++; if (if_a.b2_flush !== 1'b1) $display("FAIL lu_b2_flush got=%b exp=1", if_a.b2_flush); else passed++;
        total++; if ({if_a.b3_we, if_a.b4_we, if_a.b1_flush, if_a.b3_flush} !== 4'b1100)
            $display("FAIL lu_others got=%b exp=1100", {if_a.b3_we, if_a.b4_we, if_a.b1_flush, if_a.b3_flush}); else passed++;
        tick();
        ex_MemRead = 1'b0;
        #1;
        total++; if (if_a.pc_we !== 1'b1) $display("FAIL lu_one_bubble got=%b exp=1", if_a.pc_we); else passed++;
        total++; if (if_a.stall_count !== 16'd1) $display("FAIL lu_count got=%0d exp=1", if_a.stall_count); else passed++;
        ex_MemRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        total++; if (if_a.pc_we !== 1'b1) $display("FAIL lu_r0 got=%b exp=1", if_a.pc_we); else passed++;
        tick();
        ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
        #1;
        total++; if (if_a.pc_we !== 1'b0) $display("FAIL lu_rt_match got=%b exp=0", if_a.pc_we); else passed++;
        tick();
        ex_MemRead = 1'b0;
        #1;
        total++; if (if_a.stall_count !== 16'd2) $display("FAIL lu_count2 got=%0d exp=2", if_a.stall_count); else passed++;
        total++; if (if_a.pc_we !== 1'b1) $display("FAIL lu_no_memread got=%b exp=1", if_a.pc_we); else passed++;
    endtask

    task automatic test_branch();
        apply_reset();
        mem_Branch = 1'b1; mem_Z_flag = 1'b1;
        ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        total++; if (if_a.pc_sel_branch !== 1'b1) $display("FAIL br_pc_sel got=%b exp=1", if_a.pc_sel_branch); else passed++;
        total++; if (if_a.pc_we !== 1'b1) $display("FAIL br_pc_we got=%b exp=1", if_a.pc_we); else passed++;
        total++; if ({if_a.b1_flush, if_a.b2_flush, if_a.b3_flush, if_a.b4_we} !== 4'b1111)
            $display("FAIL br_flush got=%b exp=1111", {if_a.b1_flush, if_a.b2_flush, if_a.b3_flush, if_a.b4_we}); else passed++;
        tick();
        total++; if ({if_a.state, if_a.stall_count} !== 17'd0)
            $display("FAIL br_no_stall got=%0h exp=0", {if_a.state, if_a.stall_count}); else passed++;
        mem_Z_flag = 1'b0; ex_MemRead = 1'b0;
        #1;
        total++; if ({if_a.pc_sel_branch, if_a.pc_we, if_a.b1_flush, if_a.b2_flush, if_a.b3_flush} !== 5'b01000)
            $display("FAIL br_not_taken got=%b exp=01000",
                     {if_a.pc_sel_branch, if_a.pc_we, if_a.b1_flush, if_a.b2_flush, if_a.b3_flush}); else passed++;
        ex_MemRead = 1'b1;
        #1;
        total++; if (if_a.pc_we !== 1'b0) $display("FAIL br_nt_load_use got=%b exp=0", if_a.pc_we); else passed++;
    endtask

    task automatic test_mem_freeze();
        apply_reset();
        mem_MemRead = 1'b1; mem_Branch = 1'b1; mem_Z_flag = 1'b1;
        #1;
        total++; if ({if_a.pc_we, if_a.b1_we, if_a.b4_we, if_a.state} !== 4'b0000)
            $display("FAIL mf_c1 got=%b exp=0000", {if_a.pc_we, if_a.b1_we, if_a.b4_we, if_a.state}); else passed++;
        total++; if ({if_a.pc_sel_branch, if_a.b1_flush, if_a.b2_flush} !== 3'b000)
            $display("FAIL mf_illegal_branch got=%b exp=000", {if_a.pc_sel_branch, if_a.b1_flush, if_a.b2_flush}); else passed++;
        total++; if ({if_b.pc_we, if_b.pc_sel_branch} !== 2'b11)
            $display("FAIL mf_lat1_c1 got=%b exp=11", {if_b.pc_we, if_b.pc_sel_branch}); else passed++;
        tick();
        mem_Branch = 1'b0; mem_Z_flag = 1'b0;
        #1;
        total++; if ({if_a.pc_we, if_a.state} !== 2'b01) $display("FAIL mf_c2 got=%b exp=01", {if_a.pc_we, if_a.state}); else passed++;
        total++; if ({if_b.pc_we, if_b.state} !== 2'b10) $display("FAIL mf_lat1_c2 got=%b exp=10", {if_b.pc_we, if_b.state}); else passed++;
        tick();
        total++; if ({if_a.pc_we, if_a.b4_we, if_a.state} !== 3'b111)
            $display("FAIL mf_release got=%b exp=111", {if_a.pc_we, if_a.b4_we, if_a.state}); else passed++;
        tick();
        mem_MemRead = 1'b0; mem_MemWRITE = 1'b1;
        #1;
        total++; if (if_a.stall_count !== 16'd2) $display("FAIL mf_count got=%0d exp=2", if_a.stall_count); else passed++;
        total++; if (if_b.stall_count !== 16'd0) $display("FAIL mf_lat1_count got=%0d exp=0", if_b.stall_count); else passed++;
        total++; if ({if_a.pc_we, if_a.state} !== 2'b00)
            $display("FAIL mf_back_to_back got=%b exp=00", {if_a.pc_we, if_a.state}); else passed++;
        mem_MemWRITE = 1'b0;
    endtask

    task automatic test_reset_mid_freeze();
        apply_reset();
        mem_MemRead = 1'b1;
        #1;
        total++; if ({if_c.pc_we, if_c.state} !== 2'b00) $display("FAIL rmf_c1 got=%b exp=00", {if_c.pc_we, if_c.state}); else passed++;
        tick();
        total++; if ({if_c.pc_we, if_c.state} !== 2'b01) $display("FAIL rmf_c2 got=%b exp=01", {if_c.pc_we, if_c.state}); else passed++;
        rst = 1'b1;
        #1;
        total++; if ({if_c.pc_we, if_c.b1_flush} !== 2'b01) $display("FAIL rmf_rst_out got=%b exp=01", {if_c.pc_we, if_c.b1_flush}); else passed++;
        tick();
        rst = 1'b0; mem_MemRead = 1'b0;
        #1;
        total++; if ({if_c.state, if_c.pc_we} !== 2'b01) $display("FAIL rmf_after got=%b exp=01", {if_c.state, if_c.pc_we}); else passed++;
        total++; if (if_c.stall_count !== 16'd0) $display("FAIL rmf_count got=%0d exp=0", if_c.stall_count); else passed++;
        mem_MemRead = 1'b1;
        tick(); tick(); tick();
        total++; if ({if_c.pc_we, if_c.state} !== 2'b11) $display("FAIL rmf_refreeze got=%b exp=11", {if_c.pc_we, if_c.state}); else passed++;
        total++; if (if_c.stall_count !== 16'd3) $display("FAIL rmf_count3 got=%0d exp=3", if_c.stall_count); else passed++;
        mem_MemRead = 1'b0;
        tick();
        total++; if (if_c.state !== 1'b0) $display("FAIL rmf_back_run got=%b exp=0", if_c.state); else passed++;
    endtask

    task automatic test_saturation();
        apply_reset();
        ex_MemRead = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; id_rt = 5'd1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                total++; if (if_d.stall_count !== 4'd14) $display("FAIL sat_14 got=%0d exp=14", if_d.stall_count); else passed++;
            end
            if (i == 15) begin
                total++; if (if_d.stall_count !== 4'd15) $display("FAIL sat_15 got=%0d exp=15", if_d.stall_count); else passed++;
            end
        end
        total++; if (if_d.stall_count !== 4'd15) $display("FAIL sat_hold got=%0d exp=15", if_d.stall_count); else passed++;
        total++; if (if_a.stall_count !== 16'd20) $display("FAIL sat_wide got=%0d exp=20", if_a.stall_count); else passed++;
        idle();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        idle();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_freeze();
        test_reset_mid_freeze();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
